ioctl_upload_reader: RTL and testbench

- Responder side of the ioctl transfer channel. Serves host upload (read-back) requests by fetching bytes from core memory (cartridge/system RAM) through a req/ack memory port.
- Drives ioctl_din and ioctl_wait back to the host.
- Sits in rcastudioii beside the download (write) path. Shares the RAM port with the CPU through an external arbiter, so memory latency is variable.

---
 rtl/rcastudioii_pkg.sv | 17 +
 rtl/ioctl_upload_reader.sv | 136 +++++++++++++
 tb/tb_ioctl_upload_reader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rcastudioii_pkg.sv
// Shared types and constants for the rcastudioii ioctl transfer paths.
package rcastudioii_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // ioctl_index targets understood by the core
    localparam logic [7:0] IDX_ROM  = 8'h00;
    localparam logic [7:0] IDX_CART = 8'h01;
    localparam logic [7:0] IDX_RAM  = 8'h02;

    localparam logic [7:0] FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/ioctl_upload_reader.sv
// Host upload (read-back) responder: fetches bytes over a req/ack memory port.
// Optional IOCTL_UPLOAD_CSUM_EN adds a 16-bit sum of delivered in-range bytes.
module ioctl_upload_reader
    import rcastudioii_pkg::*;
#(
    parameter int         ADDR_W = 12,
    parameter int         DEPTH  = 4096,
    parameter logic [7:0] INDEX  = IDX_CART,
    parameter logic [7:0] FILL   = FILL_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              err_overrun
`ifdef IOCTL_UPLOAD_CSUM_EN
    ,
    output logic [15:0]       csum
`endif
);

    localparam logic [24:0] DEPTH_L = 25'(DEPTH);

    state_e              state_q, state_d;
    logic [7:0]          din_q, din_d;
    logic                wait_q, wait_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic                upload_q;

    logic up_rise, accept, in_range;

    assign up_rise  = ioctl_upload & ~upload_q;
    assign accept   = ioctl_rd & ioctl_upload & (ioctl_index == INDEX);
    assign in_range = ioctl_addr < DEPTH_L;

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        wait_d  = wait_q;
        req_d   = req_q;
        addr_d  = addr_q;
        err_d   = err_q;
        if (up_rise) err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_d = FETCH;
                        wait_d  = 1'b1;
                        req_d   = 1'b1;
                        addr_d  = ioctl_addr[ADDR_W-1:0];
                    end else begin
                        din_d = FILL;
                    end
                end
            end
            FETCH: begin
                if (ioctl_rd) err_d = 1'b1;
                if (mem_ack) begin
                    state_d = IDLE;
                    din_d   = mem_rdata;
                    wait_d  = 1'b0;
                    req_d   = 1'b0;
                end else if (!ioctl_upload) begin
                    // host gave up; release it but keep req until the arbiter acks
                    state_d = DRAIN;
                    wait_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (ioctl_rd) err_d = 1'b1;
                if (mem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            din_q    <= 8'h00;
            wait_q   <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            upload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            din_q    <= din_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            upload_q <= ioctl_upload;
        end
    end

    assign ioctl_din   = din_q;
    assign ioctl_wait  = wait_q;
    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign err_overrun = err_q;

`ifdef IOCTL_UPLOAD_CSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (up_rise)
            csum_d = 16'h0000;
        else if (state_q == FETCH && mem_ack)
            csum_d = csum_q + {8'h00, mem_rdata};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) csum_q <= 16'h0000;
        else          csum_q <= csum_d;
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: directed vector table, async reset, randomized run vs model.
module tb_ioctl_upload_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_upload, ioctl_rd, mem_ack;
    logic [7:0]  ioctl_index, mem_rdata;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait, mem_req, err_overrun;
    logic [11:0] mem_addr;
`ifdef IOCTL_UPLOAD_CSUM_EN
    logic [15:0] csum;
`endif

    ioctl_upload_reader dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err_overrun(err_overrun)
`ifdef IOCTL_UPLOAD_CSUM_EN
        , .csum(csum)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic up, input logic rd, input logic [7:0] ix,
                         input logic [24:0] ad, input logic ak, input logic [7:0] rv);
        ioctl_upload = up; ioctl_rd = rd; ioctl_index = ix;
        ioctl_addr = ad; mem_ack = ak; mem_rdata = rv;
    endtask

    typedef struct {
        logic        up, rd;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic        ack;
        logic [7:0]  rdata;
        logic [7:0]  din;
        logic        wt, rq;
        logic [11:0] maddr;
        logic        err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic up, logic rd, logic [7:0] idx, logic [24:0] addr,
                                logic ack, logic [7:0] rdata, logic [7:0] din,
                                logic wt, logic rq, logic [11:0] maddr, logic err);
        vec_t v;
        v.up = up; v.rd = rd; v.idx = idx; v.addr = addr; v.ack = ack; v.rdata = rdata;
        v.din = din; v.wt = wt; v.rq = rq; v.maddr = maddr; v.err = err;
        return v;
    endfunction

    // behavioural reference: one outstanding transfer, optionally abandoned by the host
    logic        m_busy, m_drop, m_wt, m_rq, m_er, m_pu;
    logic [7:0]  m_din;
    logic [11:0] m_ad;
    logic [15:0] m_cs;
    logic [7:0]  mem [4096];

    task automatic model_clock();
        logic rise;
        rise = ioctl_upload && !m_pu;
        if (rise) begin m_er = 1'b0; m_cs = 16'h0; end
        if (!m_busy) begin
            if (ioctl_rd && ioctl_upload && ioctl_index == 8'h01) begin
                if (ioctl_addr < 25'd4096) begin
                    m_busy = 1'b1; m_drop = 1'b0; m_wt = 1'b1; m_rq = 1'b1;
                    m_ad = ioctl_addr[11:0];
                end else begin
                    m_din = 8'hFF;
                end
            end
        end else begin
            if (ioctl_rd) m_er = 1'b1;
            if (mem_ack) begin
                if (!m_drop) begin
                    m_din = mem_rdata;
                    m_cs  = m_cs + {8'h00, mem_rdata};
                end
                m_busy = 1'b0; m_rq = 1'b0; m_wt = 1'b0;
            end else if (!m_drop && !ioctl_upload) begin
                m_drop = 1'b1; m_wt = 1'b0;
            end
        end
        m_pu = ioctl_upload;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b0, 8'h00);
        #3;
        chk("reset.din",  {24'h0, ioctl_din}, 32'h0);
        chk("reset.wait", {31'h0, ioctl_wait}, 32'h0);
        chk("reset.req",  {31'h0, mem_req}, 32'h0);
        chk("reset.addr", {20'h0, mem_addr}, 32'h0);
        chk("reset.err",  {31'h0, err_overrun}, 32'h0);
        step(); step();
        reset_n = 1'b1;

        //             up  rd  idx    addr         ack rdata  din   wt rq maddr  err
        vq.push_back(mk(1, 0, 8'h01, 25'h000010, 0, 8'h00, 8'h00, 0, 0, 12'h000, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h000010, 0, 8'h00, 8'h00, 1, 1, 12'h010, 0));
        vq.push_back(mk(1, 0, 8'h01, 25'h000010, 1, 8'hA5, 8'hA5, 0, 0, 12'h010, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h000020, 0, 8'h00, 8'hA5, 1, 1, 12'h020, 0));
        for (int i = 0; i < 5; i++)
            vq.push_back(mk(1, 0, 8'h01, 25'h000000, 0, 8'h00, 8'hA5, 1, 1, 12'h020, 0));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 1, 8'h3C, 8'h3C, 0, 0, 12'h020, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h001000, 0, 8'h00, 8'hFF, 0, 0, 12'h020, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h000000, 0, 8'h00, 8'hFF, 1, 1, 12'h000, 0));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 1, 8'h11, 8'h11, 0, 0, 12'h000, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h1000010, 0, 8'h00, 8'hFF, 0, 0, 12'h000, 0));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 1, 8'h99, 8'hFF, 0, 0, 12'h000, 0));
        vq.push_back(mk(1, 1, 8'h00, 25'h000030, 0, 8'h00, 8'hFF, 0, 0, 12'h000, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h000030, 0, 8'h00, 8'hFF, 1, 1, 12'h030, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h000030, 0, 8'h00, 8'hFF, 1, 1, 12'h030, 1));
        vq.push_back(mk(1, 1, 8'h01, 25'h000050, 1, 8'h42, 8'h42, 0, 0, 12'h030, 1));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 0, 0, 12'h030, 1));
        vq.push_back(mk(0, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 0, 0, 12'h030, 1));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 0, 0, 12'h030, 0));
        vq.push_back(mk(1, 1, 8'h01, 25'h000040, 0, 8'h00, 8'h42, 1, 1, 12'h040, 0));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 1, 1, 12'h040, 0));
        vq.push_back(mk(0, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 0, 1, 12'h040, 0));
        vq.push_back(mk(0, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 0, 1, 12'h040, 0));
        vq.push_back(mk(0, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 0, 1, 12'h040, 0));
        vq.push_back(mk(0, 0, 8'h01, 25'h000000, 1, 8'h77, 8'h42, 0, 0, 12'h040, 0));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 0, 8'h00, 8'h42, 0, 0, 12'h040, 0));
        vq.push_back(mk(0, 1, 8'h01, 25'h000050, 0, 8'h00, 8'h42, 0, 0, 12'h040, 0));
        vq.push_back(mk(1, 0, 8'h01, 25'h000000, 1, 8'h55, 8'h42, 0, 0, 12'h040, 0));

        foreach (vq[i]) begin
            drive(vq[i].up, vq[i].rd, vq[i].idx, vq[i].addr, vq[i].ack, vq[i].rdata);
            step();
            chk($sformatf("vec%0d.din", i),  {24'h0, ioctl_din},   {24'h0, vq[i].din});
            chk($sformatf("vec%0d.wait", i), {31'h0, ioctl_wait},  {31'h0, vq[i].wt});
            chk($sformatf("vec%0d.req", i),  {31'h0, mem_req},     {31'h0, vq[i].rq});
            chk($sformatf("vec%0d.addr", i), {20'h0, mem_addr},    {20'h0, vq[i].maddr});
            chk($sformatf("vec%0d.err", i),  {31'h0, err_overrun}, {31'h0, vq[i].err});
        end

        // reset asserted between edges while a fetch is outstanding
        drive(1'b1, 1'b1, 8'h01, 25'h000060, 1'b0, 8'h00);
        step();
        chk("midrst.pre_req", {31'h0, mem_req}, 32'h1);
        drive(1'b1, 1'b1, 8'h01, 25'h000060, 1'b0, 8'h00);
        step();
        chk("midrst.pre_err", {31'h0, err_overrun}, 32'h1);
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b0, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst.din",  {24'h0, ioctl_din}, 32'h0);
        chk("midrst.wait", {31'h0, ioctl_wait}, 32'h0);
        chk("midrst.req",  {31'h0, mem_req}, 32'h0);
        chk("midrst.addr", {20'h0, mem_addr}, 32'h0);
        chk("midrst.err",  {31'h0, err_overrun}, 32'h0);
        step(); step();
        reset_n = 1'b1;

        // randomized run against the reference model
        foreach (mem[i]) mem[i] = 8'($urandom);
        m_busy = 0; m_drop = 0; m_wt = 0; m_rq = 0; m_er = 0; m_pu = 0;
        m_din = 8'h00; m_ad = 12'h000; m_cs = 16'h0;
        begin
            logic up;
            up = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                if (up ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) == 0)) up = ~up;
                ioctl_upload = up;
                ioctl_rd     = ($urandom_range(0, 2) == 0);
                ioctl_index  = ($urandom_range(0, 3) != 0) ? 8'h01 : 8'($urandom);
                ioctl_addr   = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(4096, 33554431))
                                                           : 25'($urandom_range(0, 4095));
                mem_ack      = m_rq && ($urandom_range(0, 2) == 0);
                mem_rdata    = mem_ack ? mem[m_ad] : 8'($urandom);
                model_clock();
                step();
                chk($sformatf("rnd%0d.out", c),
                    {11'h0, ioctl_din, ioctl_wait, mem_req, mem_addr, err_overrun},
                    {11'h0, m_din, m_wt, m_rq, m_ad, m_er});
`ifdef IOCTL_UPLOAD_CSUM_EN
                chk($sformatf("rnd%0d.csum", c), {16'h0, csum}, {16'h0, m_cs});
`endif
            end
        end

`ifdef IOCTL_UPLOAD_CSUM_EN
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 25'h0, 1'b0, 8'h00);
        #1;
        chk("csum.reset", {16'h0, csum}, 32'h0);
        step();
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 8'h01, 25'h000100, 1'b0, 8'h00); step();
        drive(1'b1, 1'b0, 8'h01, 25'h000000, 1'b1, 8'h80); step();
        drive(1'b1, 1'b1, 8'h01, 25'h000101, 1'b0, 8'h00); step();
        drive(1'b1, 1'b0, 8'h01, 25'h000000, 1'b1, 8'h90); step();
        chk("csum.two_bytes", {16'h0, csum}, 32'h0110);
        drive(1'b1, 1'b1, 8'h01, 25'h002000, 1'b0, 8'h00); step();
        drive(1'b1, 1'b0, 8'h01, 25'h000000, 1'b0, 8'h00); step();
        chk("csum.fill_skip", {16'h0, csum}, 32'h0110);
        chk("csum.fill_din", {24'h0, ioctl_din}, 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
